// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: fetch, array, replacement and memory-bus signals of the refill controller
// Optional ICACHE_REFILL_STATS_EN adds the miss_cnt/stall_cnt counter outputs.
interface icache_refill_ctrl_if #(
  parameter int TAG_WIDTH    = 20,
  parameter int OFFSET_WIDTH = 5,
  parameter int LINE_NUM     = 16
);
  localparam int IDW = $clog2(LINE_NUM);
  logic                    req_valid;
  logic [31:0]             req_addr;
  logic                    lookup_hit;
  logic [IDW-1:0]          victim_id;
  logic                    flush;
  logic                    cpu_stall;
  logic                    repl_advance;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [31:0]             mem_req_addr;
  logic                    mem_resp_valid;
  logic [31:0]             mem_resp_data;
  logic                    mem_resp_last;
  logic                    data_we;
  logic [IDW-1:0]          data_line;
  logic [OFFSET_WIDTH-3:0] data_word;
  logic [31:0]             data_wdata;
  logic                    tag_we;
  logic [TAG_WIDTH-1:0]    tag_wdata;
  logic                    inval_all;
  logic                    refill_err;
`ifdef ICACHE_REFILL_STATS_EN
  logic [31:0]             miss_cnt;
  logic [31:0]             stall_cnt;
`endif
  modport master (
    input  req_valid, req_addr, lookup_hit, victim_id, flush,
           mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_last,
    output cpu_stall, repl_advance, mem_req_valid, mem_req_addr, data_we, data_line,
           data_word, data_wdata, tag_we, tag_wdata, inval_all, refill_err
`ifdef ICACHE_REFILL_STATS_EN
    , output miss_cnt, stall_cnt
`endif
  );
  modport slave (
    output req_valid, req_addr, lookup_hit, victim_id, flush,
           mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_last,
    input  cpu_stall, repl_advance, mem_req_valid, mem_req_addr, data_we, data_line,
           data_word, data_wdata, tag_we, tag_wdata, inval_all, refill_err
`ifdef ICACHE_REFILL_STATS_EN
    , input miss_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: instruction-cache miss/refill sequencer (one line burst per miss)
// Optional ICACHE_REFILL_STATS_EN adds miss and stall-cycle counters.
module icache_refill_ctrl #(
  parameter int TAG_WIDTH    = 20,
  parameter int OFFSET_WIDTH = 5,
  parameter int LINE_NUM     = 16
) (
  input logic clk,
  input logic reset,
  icache_refill_ctrl_if.master bus
);
  localparam int IDW   = $clog2(LINE_NUM);
  localparam int WW    = OFFSET_WIDTH - 2;
  localparam int WORDS = 2 ** WW;
  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
  state_t         state, state_n;
  logic [31:0]    line_addr;
  logic [IDW-1:0] victim;
  logic [WW-1:0]  beat;
  logic           flush_pending, inval_q, err_q;
  logic           miss, start, beat_done, line_done, stall;
  always_comb begin
    miss      = bus.req_valid & ~bus.lookup_hit;
    // a miss waits out both the flush request cycle and the invalidate cycle
    start     = (state == IDLE) & miss & ~bus.flush & ~inval_q;
    beat_done = (state == FILL) & bus.mem_resp_valid;
    line_done = beat_done & (beat == WW'(WORDS - 1));
    stall     = (state == IDLE) ? miss : 1'b1;
    state_n   = state;
    state_n   = (state == IDLE) ? (start ? REQ : IDLE) :
                (state == REQ)  ? (bus.mem_req_ready ? FILL : REQ) :
                (state == FILL) ? (line_done ? DONE : FILL) : IDLE;
    bus.cpu_stall     = stall;
    bus.mem_req_valid = (state == REQ);
    bus.mem_req_addr  = line_addr;
    bus.data_we       = beat_done;
    bus.data_line     = victim;
    bus.data_word     = beat;
    bus.data_wdata    = beat_done ? bus.mem_resp_data : 32'd0;
    bus.tag_we        = line_done;
    bus.repl_advance  = line_done;
    bus.tag_wdata     = line_addr[31 -: TAG_WIDTH];
    bus.inval_all     = inval_q;
    bus.refill_err    = err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      line_addr     <= '0;
      victim        <= '0;
      beat          <= '0;
      flush_pending <= 1'b0;
      inval_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        line_addr <= bus.req_addr & ~32'((1 << OFFSET_WIDTH) - 1);
        victim    <= bus.victim_id;
        beat      <= '0;
      end else if (beat_done) begin
        beat <= beat + 1'b1;
      end
      flush_pending <= ((state == REQ) | (state == FILL)) & (flush_pending | bus.flush);
      inval_q       <= ((state == IDLE) & bus.flush) | ((state == DONE) & (flush_pending | bus.flush));
      err_q         <= err_q | (beat_done & (bus.mem_resp_last != (beat == WW'(WORDS - 1))));
    end
  end
`ifdef ICACHE_REFILL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.miss_cnt  <= '0;
      bus.stall_cnt <= '0;
    end else begin
      bus.miss_cnt  <= bus.miss_cnt + 32'(start);
      bus.stall_cnt <= bus.stall_cnt + 32'(stall);
    end
  end
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized transaction-level checks of the icache refill sequencer
module tb_icache_refill_ctrl;
  localparam int TW = 20, OW = 5, LN = 16, IDW = 4, WORDS = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  logic exp_err = 1'b0;
  icache_refill_ctrl_if #(.TAG_WIDTH(TW), .OFFSET_WIDTH(OW), .LINE_NUM(LN)) bus();
  icache_refill_ctrl #(.TAG_WIDTH(TW), .OFFSET_WIDTH(OW), .LINE_NUM(LN)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_addr = 0; bus.lookup_hit = 0; bus.victim_id = 0; bus.flush = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 0; bus.mem_resp_last = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // one complete miss; abort>=0 applies reset once that many beats have been written
  task automatic run_miss(input logic [31:0] addr, input logic [IDW-1:0] vid, input int wait_n,
                          input bit gaps, input int bad, input bit flush_fill, input int abort);
    logic [31:0] d;
    logic v;
    int k = 0, cyc = 0;
    logic [31:0] line = addr & 32'hffff_ffe0;
    bus.req_valid = 1; bus.req_addr = addr; bus.lookup_hit = 0; bus.victim_id = vid;
    bus.flush = 0; bus.mem_resp_valid = 0; bus.mem_req_ready = 0;
    #2; checks++;
    if ({bus.cpu_stall, bus.mem_req_valid, bus.inval_all} !== 3'b100) begin
      errors++; $display("FAIL miss_idle: stall,req,inval=%b expected 100", {bus.cpu_stall, bus.mem_req_valid, bus.inval_all});
    end
    step();
    bus.req_valid = 0; bus.victim_id = ~vid; bus.req_addr = $urandom;
    for (int i = 0; i <= wait_n; i++) begin
      bus.mem_req_ready = (i == wait_n);
      #2; checks++;
      if ({bus.cpu_stall, bus.mem_req_valid, bus.data_we, bus.mem_req_addr} !== {3'b110, line}) begin
        errors++; $display("FAIL req_phase: stall,req,we=%b addr=%h expected 110 addr=%h",
                           {bus.cpu_stall, bus.mem_req_valid, bus.data_we}, bus.mem_req_addr, line);
      end
      step();
    end
    bus.mem_req_ready = 0;
    while (k < WORDS && cyc < 100) begin
      if (k == abort) begin
        reset = 1; bus.mem_resp_valid = 1; step(); reset = 0; exp_err = 0;
        for (int j = 0; j < 3; j++) begin
          bus.mem_resp_valid = 1; bus.mem_resp_data = $urandom; bus.mem_resp_last = (j == 2);
          #2; checks++;
          if ({bus.cpu_stall, bus.mem_req_valid, bus.data_we, bus.tag_we, bus.refill_err} !== 5'b0) begin
            errors++; $display("FAIL abort_idle: stall,req,we,tag,err=%b expected 00000",
                               {bus.cpu_stall, bus.mem_req_valid, bus.data_we, bus.tag_we, bus.refill_err});
          end
          step();
        end
        idle_inputs();
        return;
      end
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = $urandom;
      bus.mem_resp_valid = v; bus.mem_resp_data = d;
      bus.mem_resp_last = (k == WORDS - 1) ^ (k == bad);
      bus.flush = flush_fill && cyc == 0;
      #2; checks++;
      if ({bus.cpu_stall, bus.data_we, bus.tag_we, bus.repl_advance, bus.inval_all} !==
          {1'b1, v, v && k == WORDS - 1, v && k == WORDS - 1, 1'b0}) begin
        errors++; $display("FAIL fill_ctl beat %0d: stall,we,tag,adv,inval=%b expected 1%b%b%b0", k,
                           {bus.cpu_stall, bus.data_we, bus.tag_we, bus.repl_advance, bus.inval_all},
                           v, v && k == WORDS - 1, v && k == WORDS - 1);
      end
      if (v) begin
        checks++;
        if ({bus.data_line, bus.data_word, bus.data_wdata} !== {vid, 3'(k), d}) begin
          errors++; $display("FAIL fill_data: line=%0d word=%0d data=%h expected line=%0d word=%0d data=%h",
                             bus.data_line, bus.data_word, bus.data_wdata, vid, k, d);
        end
        if (k == WORDS - 1) begin
          checks++;
          if (bus.tag_wdata !== addr[31:12]) begin
            errors++; $display("FAIL tag_wdata: got %h expected %h", bus.tag_wdata, addr[31:12]);
          end
        end
        k++;
      end
      cyc++;
      step();
    end
    bus.mem_resp_valid = 0; bus.flush = 0; bus.mem_resp_last = 0;
    checks++;
    if (k != WORDS) begin
      errors++; $display("FAIL fill_timeout: beats=%0d expected %0d", k, WORDS);
    end
    if (bad >= 0 && bad < WORDS) exp_err = 1;
    bus.req_valid = 1; bus.req_addr = addr; bus.lookup_hit = 1;
    #2; checks++;
    if ({bus.cpu_stall, bus.mem_req_valid, bus.data_we, bus.tag_we, bus.inval_all, bus.refill_err} !==
        {5'b10000, exp_err}) begin
      errors++; $display("FAIL done_cycle: stall,req,we,tag,inval,err=%b expected 10000%b",
                         {bus.cpu_stall, bus.mem_req_valid, bus.data_we, bus.tag_we, bus.inval_all, bus.refill_err}, exp_err);
    end
    step();
    #2; checks++;
    if ({bus.cpu_stall, bus.mem_req_valid, bus.inval_all} !== {2'b00, flush_fill}) begin
      errors++; $display("FAIL replay_hit: stall,req,inval=%b expected 00%b",
                         {bus.cpu_stall, bus.mem_req_valid, bus.inval_all}, flush_fill);
    end
    step();
    #2; checks++;
    if ({bus.mem_req_valid, bus.inval_all} !== 2'b00) begin
      errors++; $display("FAIL after_replay: req,inval=%b expected 00", {bus.mem_req_valid, bus.inval_all});
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; bus.mem_resp_valid = 1; step(); step();
    #2; checks++;
    if ({bus.cpu_stall, bus.repl_advance, bus.mem_req_valid, bus.mem_req_addr, bus.data_we, bus.data_line,
         bus.data_word, bus.data_wdata, bus.tag_we, bus.tag_wdata, bus.inval_all, bus.refill_err} !== '0) begin
      errors++; $display("FAIL reset_state: outputs not all zero (req=%b addr=%h we=%b word=%0d)",
                         bus.mem_req_valid, bus.mem_req_addr, bus.data_we, bus.data_word);
    end
    reset = 0; idle_inputs(); step();
  endtask

  task automatic test_hit();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1; bus.lookup_hit = 1; bus.req_addr = $urandom;
      bus.mem_resp_valid = 1; bus.mem_resp_data = $urandom;
      #2; checks++;
      if ({bus.cpu_stall, bus.mem_req_valid, bus.data_we} !== 3'b000) begin
        errors++; $display("FAIL hit: stall,req,we=%b expected 000", {bus.cpu_stall, bus.mem_req_valid, bus.data_we});
      end
      step();
    end
    idle_inputs(); step();
  endtask

  task automatic test_err_and_reset();
    run_miss(32'h4000_0abc, 3, 1, 0, 3, 0, -1);
    reset = 1; step(); reset = 0; exp_err = 0;
    #2; checks++;
    if (bus.refill_err !== 1'b0) begin
      errors++; $display("FAIL err_clear: refill_err=%b expected 0", bus.refill_err);
    end
    step();
  endtask

  task automatic test_flush_idle_miss();
    bus.req_valid = 1; bus.req_addr = 32'h0000_8040; bus.lookup_hit = 0; bus.victim_id = 9; bus.flush = 1;
    #2; checks++;
    if ({bus.cpu_stall, bus.inval_all} !== 2'b10) begin
      errors++; $display("FAIL flush_miss_req: stall,inval=%b expected 10", {bus.cpu_stall, bus.inval_all});
    end
    step();
    bus.flush = 0;
    #2; checks++;
    if ({bus.mem_req_valid, bus.inval_all} !== 2'b01) begin
      errors++; $display("FAIL flush_miss_inval: req,inval=%b expected 01", {bus.mem_req_valid, bus.inval_all});
    end
    step();
    run_miss(32'h0000_8040, 9, 0, 0, -1, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int bad = $urandom_range(0, 15);
      run_miss($urandom, 4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               bad < WORDS ? bad : -1, 1'($urandom_range(0, 1)), -1);
      if (bad < WORDS) begin
        reset = 1; step(); reset = 0; exp_err = 0;
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_hit();
    run_miss(32'h0000_1234, 5, 2, 0, -1, 0, -1);
    run_miss(32'h1234_5678, 11, 0, 1, -1, 0, -1);
    test_err_and_reset();
    run_miss(32'h0000_2000, 2, 1, 0, -1, 1, -1);
    run_miss(32'h0000_3000, 7, 0, 0, -1, 0, 5);
    run_miss(32'h0000_3000, 8, 1, 0, -1, 0, -1);
    test_flush_idle_miss();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
